// File: rtl/crc_dma_feeder.sv
// crc_dma_feeder
//  Bus-mastering feeder upstream of the CRC32 peripheral. Software programs a
//  source address (SRC) and a word count (LEN), then writes START. Each word is
//  read from memory on a valid/ready master port and written into the CRC DATA
//  register through the CRC slave port. DONE (and irq when IRQ_EN is set) is
//  raised when the last word has been accepted by the CRC.
// Ports
//  clk, reset            system clock, synchronous active-high reset
//  select/wstrb/addr/    CPU slave port: 0x0 CTRL, 0x4 SRC, 0x8 LEN, 0xC REMAIN;
//  data_i/ready/data_o   ready and read data are registered (one cycle after select)
//  mem_*                 memory read master, one outstanding request
//  crc_*                 CRC slave master, one-cycle crc_select per pushed word
//  irq                   level, DONE & IRQ_EN
module crc_dma_feeder #(
  parameter int unsigned LEN_W         = 16,
  parameter logic [3:0]  CRC_DATA_ADDR = 4'h8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        crc_select,
  output logic [3:0]  crc_wstrb,
  output logic [3:0]  crc_addr,
  output logic [31:0] crc_data,
  input  logic        crc_ready,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PUSH, S_WAIT_CRC} state_t;

  state_t             state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [31:0]        ptr_q, ptr_d;
  logic [31:0]        crc_data_q, crc_data_d;
  logic [31:0]        data_o_q, data_o_d;
  logic               ready_q, ready_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;

  logic wr, rd, ctrl_wr, start, abort, busy;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    len_d      = len_q;
    remain_d   = remain_q;
    ptr_d      = ptr_q;
    crc_data_d = crc_data_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    abort_d    = abort_q;
    data_o_d   = '0;

    wr      = select && (wstrb != 4'h0);
    rd      = select && (wstrb == 4'h0);
    ctrl_wr = wr && (addr == 4'h0);
    start   = ctrl_wr && data_i[0];
    abort   = ctrl_wr && data_i[1];
    busy    = (state_q != S_IDLE);
    ready_d = select;

    if (rd) begin
      case (addr)
        4'h0:    data_o_d = {29'd0, irq_en_q, done_q, busy};
        4'h4:    data_o_d = {src_q[31:2], 2'b00};
        4'h8:    data_o_d = 32'(len_q);
        4'hC:    data_o_d = 32'(remain_q);
        default: data_o_d = '0;
      endcase
    end

    // DONE_CLR is applied first so that a START in the same write overrides it.
    if (ctrl_wr) begin
      irq_en_d = data_i[2];
      if (data_i[3]) done_d = 1'b0;
    end

    if (wr && !busy) begin
      if (addr == 4'h4) src_d = {data_i[31:2], 2'b00};
      if (addr == 4'h8) len_d = data_i[LEN_W-1:0];
    end

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          ptr_d    = src_q;
          remain_d = len_q;
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (mem_ready) begin
          crc_data_d = mem_rdata;
          state_d    = S_PUSH;
        end
      end
      S_PUSH: begin
        // The strobe of this cycle is already on the bus; abort only stops
        // the handshake tracking that would follow it.
        state_d = abort ? S_IDLE : S_WAIT_CRC;
      end
      S_WAIT_CRC: begin
        // An abort arriving here is remembered until the CRC acknowledges.
        if (abort) abort_d = 1'b1;
        if (crc_ready) begin
          ptr_d    = ptr_q + 32'd4;
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (abort || abort_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      len_q      <= '0;
      remain_q   <= '0;
      ptr_q      <= '0;
      crc_data_q <= '0;
      data_o_q   <= '0;
      ready_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      len_q      <= len_d;
      remain_q   <= remain_d;
      ptr_q      <= ptr_d;
      crc_data_q <= crc_data_d;
      data_o_q   <= data_o_d;
      ready_q    <= ready_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign ready      = ready_q;
  assign data_o     = data_o_q;
  assign mem_valid  = (state_q == S_FETCH);
  assign mem_addr   = {ptr_q[31:2], 2'b00};
  assign crc_select = (state_q == S_PUSH);
  assign crc_wstrb  = crc_select ? 4'hF : 4'h0;
  assign crc_addr   = CRC_DATA_ADDR;
  assign crc_data   = crc_data_q;
  assign irq        = done_q & irq_en_q;

endmodule

// File: tb/tb_crc_dma_feeder.sv
// Testbench for crc_dma_feeder: memory and CRC responders with programmable
// latency, scoreboard queues of expected read addresses and pushed words, and
// a reference CRC32 over the pushed stream.
module tb_crc_dma_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        select;
  logic [3:0]  wstrb;
  logic [3:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        crc_select;
  logic [3:0]  crc_wstrb;
  logic [3:0]  crc_addr;
  logic [31:0] crc_data;
  logic        crc_ready;
  logic        irq;

  crc_dma_feeder #(.LEN_W(16), .CRC_DATA_ADDR(4'h8)) dut (
    .clk(clk), .reset(reset), .select(select), .wstrb(wstrb), .addr(addr),
    .data_i(data_i), .ready(ready), .data_o(data_o),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .crc_select(crc_select), .crc_wstrb(crc_wstrb), .crc_addr(crc_addr),
    .crc_data(crc_data), .crc_ready(crc_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  int          mem_lat = 0;
  int          crc_lat = 0;
  int          mem_cnt = 0;
  int          crc_cnt = 0;
  int          n_mem_acc = 0;
  bit          crc_pend = 1'b0;
  logic [31:0] crc_held = '0;
  logic [31:0] crc_acc = 32'hFFFF_FFFF;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0300) return 32'h6463_6261;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reflected CRC-32 (poly 0x04C11DB7), bytes taken LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 4; b++) begin
      r = r ^ {24'd0, w[8*b +: 8]};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Memory responder: acknowledges after mem_lat idle cycles, one-cycle pulse.
  always @(negedge clk) begin
    logic [31:0] e;
    if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (mem_valid) begin
      if (mem_cnt >= mem_lat) begin
        e = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'h0000_0001;
        check_eq("mem_addr", mem_addr, e);
        mem_ready = 1'b1;
        mem_rdata = mem_word(mem_addr);
        mem_cnt   = 0;
        n_mem_acc++;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // CRC responder: checks each push, then acks after crc_lat further cycles.
  always @(negedge clk) begin
    logic [31:0] e;
    if (crc_ready) crc_ready = 1'b0;
    if (crc_select) begin
      e = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 32'h0BAD_0001;
      check_eq("crc_data", crc_data, e);
      check_eq("crc_wstrb", {28'd0, crc_wstrb}, 32'hF);
      check_eq("crc_addr", {28'd0, crc_addr}, 32'h8);
      crc_pend = 1'b1;
      crc_cnt  = 0;
      crc_held = crc_data;
      crc_acc  = crc_step(crc_acc, crc_data);
    end else if (crc_pend) begin
      check_eq("crc_hold", crc_data, crc_held);
      if (crc_cnt >= crc_lat) begin
        crc_ready = 1'b1;
        crc_pend  = 1'b0;
      end else begin
        crc_cnt++;
      end
    end
  end

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    select = 1'b1; wstrb = 4'hF; addr = a; data_i = d;
    @(posedge clk); #1;
    select = 1'b0; wstrb = 4'h0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    select = 1'b1; wstrb = 4'h0; addr = a;
    @(posedge clk); #1;
    select = 1'b0;
    check_eq("slave_ready", {31'd0, ready}, 32'd1);
    d = data_o;
  endtask

  task automatic expect_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    cpu_read(a, v);
    check_eq(tag, v, exp);
  endtask

  task automatic start_run(input logic [31:0] src, input logic [31:0] len, input bit ien);
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(src + 32'(4 * i));
      exp_data_q.push_back(mem_word(src + 32'(4 * i)));
    end
    cpu_write(4'h4, src);
    cpu_write(4'h8, len);
    cpu_write(4'h0, {29'd0, ien, 2'b01});
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] v;
    v = 32'd1;
    for (int i = 0; i < 300; i++) begin
      cpu_read(4'h0, v);
      if (!v[0]) return;
    end
    check_eq({tag, "_timeout"}, {31'd0, v[0]}, 32'd0);
  endtask

  task automatic check_drained(input string tag);
    check_eq(tag, 32'(exp_addr_q.size() + exp_data_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b1; select = 1'b0; wstrb = '0; addr = '0; data_i = '0;
    mem_ready = 1'b0; mem_rdata = '0; crc_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check_eq("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_eq("rst_crc_select", {31'd0, crc_select}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    expect_reg("rst_ctrl", 4'h0, 32'd0);
    expect_reg("rst_src", 4'h4, 32'd0);
    expect_reg("rst_len", 4'h8, 32'd0);
    expect_reg("rst_remain", 4'hC, 32'd0);

    // 1: three words, zero-wait memory
    base = n_mem_acc;
    start_run(32'h0000_0100, 3, 1'b0);
    wait_idle("t1");
    expect_reg("t1_ctrl", 4'h0, 32'b010);
    expect_reg("t1_remain", 4'hC, 32'd0);
    check_eq("t1_reads", 32'(n_mem_acc - base), 32'd3);
    check_drained("t1_drained");

    // 2: single word "abcd" through the reference CRC
    crc_acc = 32'hFFFF_FFFF;
    start_run(32'h0000_0300, 1, 1'b0);
    wait_idle("t2");
    check_eq("t2_crc", ~crc_acc, 32'hED82_CD11);
    check_drained("t2_drained");

    // 3: LEN=0, irq follows IRQ_EN; DONE_CLR together with START loses
    cpu_write(4'h0, 32'h8);
    expect_reg("t3_cleared", 4'h0, 32'd0);
    cpu_write(4'h8, 32'd0);
    cpu_write(4'h0, 32'hD);
    check_eq("t3_irq_on", {31'd0, irq}, 32'd1);
    check_eq("t3_no_fetch", {31'd0, mem_valid}, 32'd0);
    expect_reg("t3_ctrl_ien", 4'h0, 32'b110);
    cpu_write(4'h0, 32'h1);
    check_eq("t3_irq_off", {31'd0, irq}, 32'd0);
    expect_reg("t3_ctrl", 4'h0, 32'b010);
    check_drained("t3_drained");

    // 4: abort during the second fetch
    mem_lat = 8;
    base = n_mem_acc;
    exp_addr_q.push_back(32'h0000_0200);
    exp_data_q.push_back(mem_word(32'h0000_0200));
    cpu_write(4'h4, 32'h0000_0200);
    cpu_write(4'h8, 32'd4);
    cpu_write(4'h0, 32'h1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (n_mem_acc == base + 1 && mem_valid) break;
    end
    check_eq("t4_second_fetch", {31'd0, mem_valid}, 32'd1);
    cpu_write(4'h0, 32'h2);
    check_eq("t4_valid_drop", {31'd0, mem_valid}, 32'd0);
    expect_reg("t4_ctrl", 4'h0, 32'd0);
    expect_reg("t4_remain", 4'hC, 32'd3);
    repeat (12) @(posedge clk);
    check_eq("t4_reads", 32'(n_mem_acc - base), 32'd1);
    check_drained("t4_drained");

    // 5: address wrap
    mem_lat = 1;
    start_run(32'hFFFF_FFFC, 2, 1'b1);
    wait_idle("t5");
    expect_reg("t5_ctrl", 4'h0, 32'b110);
    check_eq("t5_irq", {31'd0, irq}, 32'd1);
    check_drained("t5_drained");

    // 6: writes while busy ignored; slow CRC ack
    mem_lat = 0;
    crc_lat = 5;
    start_run(32'h0000_0400, 3, 1'b0);
    cpu_write(4'h4, 32'hDEAD_0000);
    cpu_write(4'h8, 32'd7);
    cpu_write(4'h0, 32'h1);
    wait_idle("t6");
    expect_reg("t6_src", 4'h4, 32'h0000_0400);
    expect_reg("t6_len", 4'h8, 32'd3);
    expect_reg("t6_ctrl", 4'h0, 32'b010);
    repeat (10) @(posedge clk);
    check_drained("t6_drained");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
